// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared defaults and MMIO map for the uart rx byte buffer
package uart_rx_fifo_pkg;

  localparam int UART_RX_FIFO_DEPTH = 16;
  localparam int UART_RX_THRESH     = 8;
  localparam int UART_RX_TIMEOUT    = 4096;

  // Byte offsets within the uart MMIO window, decoded by mem.
  typedef enum logic [3:0] {
    UART_RX_REG_DATA    = 4'h0,
    UART_RX_REG_STATUS  = 4'h4,
    UART_RX_REG_OVF_CLR = 4'h8
  } uart_rx_reg_e;

  typedef struct packed {
    logic irq;
    logic overflow;
    logic ready;
  } uart_rx_status_t;

  function automatic logic [7:0] uart_rx_status_word(input uart_rx_status_t st);
    return {5'b0, st.irq, st.overflow, st.ready};
  endfunction

endpackage

// File: rtl/uart_rx_fifo_idle_timer.sv
// rtl/uart_rx_fifo_idle_timer.sv - saturating idle counter that flags expiry at TIMEOUT
module rx_idle_timer
  import uart_rx_fifo_pkg::*;
#(
  parameter int TIMEOUT = UART_RX_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clr_i) begin
      timer_d = '0;
    end else if (en_i && (timer_q != LIMIT)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign expired_o = (timer_q == LIMIT);

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - rx byte FIFO between uart receiver and mem, with threshold/idle irq
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter  int DEPTH   = UART_RX_FIFO_DEPTH,
  parameter  int THRESH  = UART_RX_THRESH,
  parameter  int TIMEOUT = UART_RX_TIMEOUT,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          ren,
  output logic [7:0]    rdata,
  output logic          ready,
  output logic [CW-1:0] count,
  output logic          irq,
  output logic          overflow,
  input  logic          clr_ovf
);

  localparam int AW = CW - 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  logic [7:0]    mem_q [DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          irq_q, irq_d;

  logic full, empty, push, pop, drop, timeout_flag;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign pop   = ren && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push  = in_valid && (!full || pop);
  assign drop  = in_valid && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    irq_d = (count_q >= THRESH_C) || timeout_flag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  // Storage is deliberately left unreset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

  rx_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (push || pop || empty),
    .en_i     (!empty),
    .expired_o(timeout_flag)
  );

  assign rdata    = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign ready    = !empty;
  assign count    = count_q;
  assign irq      = irq_q;
  assign overflow = overflow_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer between the uart receiver and the mem MMIO block.
- Captures each completed RX byte, holds up to DEPTH bytes, and presents the head byte to mem for MMIO reads.
- Raises a level interrupt, consumed through the interrupts vector, when the fill threshold is reached or when data has sat idle too long.
- Replaces the single-byte rx_ready path so back-to-back bytes are not lost while the CPU is stalled.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
THRESH, 8, fill level at or above which irq asserts; range 1..DEPTH
TIMEOUT, 4096, idle cycles with non-empty FIFO before irq asserts; minimum 2
CW, $clog2(DEPTH)+1, width of count and pointers (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  one-cycle strobe from uart: in_data holds a completed byte
in_data  in  8  received byte
ren  in  1  pop request from mem (MMIO read of RX data register)
rdata  out  8  head byte; 8'h00 when empty
ready  out  1  FIFO non-empty
count  out  CW  current occupancy, 0..DEPTH
irq  out  1  level interrupt request
overflow  out  1  sticky: a byte was dropped because the FIFO was full
clr_ovf  in  1  one-cycle strobe that clears overflow

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, count=0, overflow=0, idle timer=0, timeout flag=0.
  - Resulting outputs: ready=0, irq=0, rdata=8'h00.
  - Reset mid-stream discards all contents. Storage array is not reset.
- Pointers are CW bits wide and wrap modulo DEPTH on the low bits.
  - full = (count==DEPTH); empty = (count==0).
- Push: accepted on a clk edge when in_valid && (!full || pop).
  - Byte is written at wr_ptr; wr_ptr increments.
- Pop: occurs when ren && !empty. rd_ptr increments.
  - ren while empty is ignored: no pointer change, no error flag.
- Output timing:
  - rdata = storage[rd_ptr], combinational from registered state, so it is valid in the same cycle ready=1.
  - mem samples rdata in the cycle it asserts ren.
  - Push-to-visible latency: 1 cycle (ready and rdata update after the push edge).
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous cases:
  - Full, push+pop: both happen, count stays DEPTH, overflow not set.
  - Empty, push+ren: pop ignored, push accepted, count becomes 1.
- Overflow:
  - in_valid while full with no pop: byte dropped, FIFO contents unchanged, overflow set to 1.
  - clr_ovf clears it. If set and clear occur in the same cycle, set wins.
- Idle timer:
  - Resets to 0 on any push, any pop, or while empty.
  - Otherwise increments, saturating at TIMEOUT.
  - Timeout flag = (timer==TIMEOUT). It clears the cycle after the next push/pop or on becoming empty.
- irq = (count >= THRESH) || timeout_flag. Registered, so it updates 1 cycle after the triggering condition.

Decomposition:
- Shared package: UART_RX_FIFO_DEPTH, UART_RX_THRESH, UART_RX_TIMEOUT defaults, and the MMIO offsets for the RX data, status and overflow-clear registers used by mem.
- One sub-module: rx_idle_timer (saturating counter with clear and enable, outputs the expired flag), parameterised by TIMEOUT.
- Storage and pointers stay in uart_rx_fifo.

Test Plan:
- Reset, then push 8'h41 -> next cycle ready=1, rdata=8'h41, count=1, irq=0. ren for one cycle -> ready=0, rdata=8'h00, count=0.
- Push 8 bytes 0x01..0x08 (THRESH=8) -> irq rises one cycle after the 8th push. Pop 1 -> irq falls (timeout not reached). Remaining pops return 0x02..0x08 in order.
- Push 17 bytes 0x00..0x10 (DEPTH=16) -> count=16, overflow=1, and 0x10 is dropped. Pop all -> sequence 0x00..0x0F. clr_ovf -> overflow=0. clr_ovf coincident with a drop -> overflow stays 1.
- Fill to 16, then assert in_valid=0xAA with ren in the same cycle -> rdata read 0x00, count stays 16, overflow=0. Drain -> last byte is 0xAA (exercises pointer wrap).
- Push 1 byte, then idle with TIMEOUT=16 -> irq=0 through cycle 16, irq=1 after the timer saturates. Pop -> irq=0 next cycle, timer=0.
- Push 3 bytes, assert rst mid-sequence asynchronously (not clock-aligned) -> ready=0, count=0, irq=0, overflow=0 immediately. After release, a push of 0x55 reads back 0x55.
